// File: rtl/seq_mult_param.sv
// seq_mult_param: serial shift-add multiplier, WIDTH-bit operands, 2*WIDTH-bit product.
// Signed operands are reduced to magnitudes on capture; the sign is reapplied once
// after WIDTH add/shift steps, so latency does not depend on the data.
module seq_mult_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_SIGN = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   mag_a_q, mag_a_d;
    logic               neg_q, neg_d;
    // Upper WIDTH+1 bits hold the running partial sum (carry kept), lower WIDTH the multiplier.
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               out_valid_q, out_valid_d;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     acc_hi;
    logic [WIDTH:0]     acc_sum;
    logic [WIDTH:0]     acc_hi_nxt;

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_CALC) || (state_q == S_SIGN);
    assign out_valid = out_valid_q;
    assign product   = product_q;

    // Operand magnitudes and the conditional add of one multiplier bit.
    always_comb begin
        a_mag      = (signed_op && a[WIDTH-1]) ? -a : a;
        b_mag      = (signed_op && b[WIDTH-1]) ? -b : b;
        acc_hi     = acc_q[2*WIDTH:WIDTH];
        acc_sum    = acc_hi + {1'b0, mag_a_q};
        acc_hi_nxt = acc_q[0] ? acc_sum : acc_hi;
    end

    // Next-state logic for the handshake FSM and datapath registers.
    always_comb begin
        state_d     = state_q;
        mag_a_d     = mag_a_q;
        neg_d       = neg_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        product_d   = product_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mag_a_d = a_mag;
                    neg_d   = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d   = {{(WIDTH + 1){1'b0}}, b_mag};
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d = {1'b0, acc_hi_nxt, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_SIGN;
                end
            end
            S_SIGN: begin
                product_d = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
                state_d   = S_DONE;
            end
            default: begin
                // First DONE cycle raises out_valid; it then holds until accepted.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mag_a_q     <= '0;
            neg_q       <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mag_a_q     <= mag_a_d;
            neg_q       <= neg_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
